exe_muldiv_unit: RTL
====================

EXE_MULDIV_UNIT -- requirements
Module: exe_muldiv_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, with ports named as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
REQ-002 Input ports SHALL be:
- EXE_busA  in  32  rs operand from the ID/EX register.
- EXE_busB  in  32  rt operand from the ID/EX register.
- EXE_OP  in  6  opcode of the instruction in EXE.
- EXE_Funct  in  6  function field of the instruction in EXE.
- EXE_Valid  in  1  EXE holds a real instruction, not a bubble.
- EXE_Hold  in  1  EXE is frozen this cycle by another stall source.
- EXE_Flush  in  1  the instruction in EXE is squashed this cycle.
REQ-003 Output ports SHALL be:
- md_busy  out  1  an iterative operation is in flight.
- md_stall  out  1  request to freeze IF/ID/EXE.
- md_rdata  out  32  MFHI/MFLO result for the EXE writeback mux.
- md_hi  out  32  architectural HI.
- md_lo  out  32  architectural LO.

Function
REQ-004 Decode SHALL apply only when EXE_OP=0x00, with these funct values:
- MULT=0x18, MULTU=0x19, DIV=0x1A, DIVU=0x1B.
- MFHI=0x10, MTHI=0x11, MFLO=0x12, MTLO=0x13.
- hilo_use = any of the eight above.
REQ-005 Qualifier: act = EXE_Valid & !EXE_Hold & !EXE_Flush.
REQ-006 md_stall SHALL be combinational: EXE_Valid & hilo_use & md_busy; the stall SHALL NOT depend on EXE_Flush.
REQ-007 FSM states SHALL be IDLE, RUN and FIX, with md_busy = (state != IDLE).
REQ-008 In IDLE, act & MULT/MULTU/DIV/DIVU SHALL, at the edge ending cycle T:
- latch the operand magnitudes (signed ops use absolute values) and the result signs;
- clear the step counter;
- enter RUN.
REQ-009 RUN SHALL perform exactly one shift-add (multiply) or restoring-subtract (divide) step per cycle, for 32 steps, then enter FIX.
REQ-010 FIX SHALL last one cycle, apply sign correction, write HI/LO at its closing edge and return to IDLE.
- md_busy is high in cycles T+1..T+33.
- New HI/LO are visible from cycle T+34.
REQ-011 Multiply results SHALL be HI:LO = 64-bit product, signed for MULT and unsigned for MULTU.
REQ-012 Divide results SHALL be LO = quotient and HI = remainder.
- The quotient truncates toward zero.
- The remainder takes the sign of the dividend.
REQ-013 Divisor 0 SHALL give HI=rs and LO=0xFFFFFFFF, with the same latency, for both DIV and DIVU.
REQ-014 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-015 MTHI/MTLO with act in IDLE SHALL write HI/LO from EXE_busA at the closing edge, with no busy period.
REQ-016 md_rdata SHALL be combinational: HI for MFHI, LO for MFLO, otherwise 0.
- While md_busy is high, md_rdata shows the old value; md_stall prevents its use.
REQ-017 An operation in flight SHALL be unaffected by EXE_Flush and EXE_Hold.
- The issuing instruction has already left EXE.
- Flush and hold suppress only new starts and new MTHI/MTLO writes.
REQ-018 A hilo_use instruction arriving while md_busy is high SHALL NOT start or write.
- It is stalled and issues in the first cycle after md_busy falls.
REQ-019 A start SHALL occur at most once per instruction.
- The EXE_Hold qualification prevents a repeated start while EXE is frozen.

Reset
REQ-020 rst_n=0 at a clock edge SHALL force:
- state=IDLE, step counter=0;
- HI=0, LO=0, all datapath registers 0;
- md_busy=0, md_stall=0, md_rdata=0.
REQ-021 Reset asserted during RUN or FIX SHALL abort the operation with no HI/LO update.
- Operation proceeds normally from the first edge at which rst_n=1.

Configuration
REQ-022 Macro MULDIV_FAST_MUL_EN SHALL select the multiply implementation.
- Defined: MULT/MULTU are single-cycle combinational multiplies that write HI/LO at the closing edge of cycle T and never assert md_busy; DIV/DIVU are unchanged.
- Undefined: multiplies use the 34-cycle iterative path of REQ-008..REQ-010.

Structure
REQ-023 Package muldiv_pkg SHALL hold:
- the SPECIAL opcode constant;
- the eight funct constants;
- the FSM state encoding;
- step-count constant 32.
REQ-024 The restoring divide step and sign fix SHALL be the sub-module exe_div_core, instantiated once; multiply, FSM and HI/LO stay in the top.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- MULT 0xFFFFFFFE x 0x00000003 issued at T -> md_busy high for T+1..T+33; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/0 -> LO=0xFFFFFFFF, HI=100.
- MFLO in EXE at T+1 after DIVU 100/7 -> md_stall=1 for T+1..T+33; at T+34 md_rdata=14 and md_stall=0.
- MULTU with EXE_Flush=1 -> no start, HI/LO unchanged; MULTU with EXE_Hold=1 for 3 cycles then released -> exactly one start.
- rst_n=0 at T+10 of a DIV -> state IDLE, HI=LO=0; next MTHI 0x12345678 -> md_hi=0x12345678 one edge later.
- With MULDIV_FAST_MUL_EN defined: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 next edge, md_busy never 1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared decode constants, FSM encoding and helpers for the EXE-stage HI/LO unit.
package muldiv_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   localparam int unsigned MD_STEPS = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } mdState_e;

   // Two's-complement magnitude; 0x80000000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [31:0] absVal(input logic [31:0] value, input logic isSigned);
      return (isSigned && value[31]) ? (32'd0 - value) : value;
   endfunction

endpackage

// File: rtl/exe_div_core.sv
// Restoring-divide step and final sign correction for the HI/LO unit (purely combinational).
module exe_div_core (
   input  logic [31:0] rem_i,
   input  logic [31:0] quo_i,
   input  logic [31:0] divisor_i,
   input  logic        negQ_i,
   input  logic        negR_i,
   input  logic        divZero_i,
   output logic [31:0] remStep_o,
   output logic [31:0] quoStep_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   logic [32:0] trial;
   logic [31:0] trialSub;
   logic        fits;

   // The partial remainder stays below the divisor, so the shifted trial fits in 33 bits
   // and the accepted difference always fits back in 32.
   assign trial     = {rem_i, quo_i[31]};
   assign fits      = (trial >= {1'b0, divisor_i});
   assign trialSub  = trial[31:0] - divisor_i;
   assign remStep_o = fits ? trialSub : trial[31:0];
   assign quoStep_o = {quo_i[30:0], fits};

   // A zero divisor leaves the dividend magnitude in the remainder, so re-signing it restores rs.
   assign hi_o = negR_i ? (32'd0 - rem_i) : rem_i;
   assign lo_o = divZero_i ? 32'hFFFF_FFFF : (negQ_i ? (32'd0 - quo_i) : quo_i);

endmodule

// File: rtl/exe_muldiv_unit.sv
// EXE-stage HI/LO unit: iterative MULT/MULTU/DIV/DIVU plus MFHI/MFLO/MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies; divides stay iterative either way.
module exe_muldiv_unit
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] EXE_busA,
   input  logic [31:0] EXE_busB,
   input  logic [5:0]  EXE_OP,
   input  logic [5:0]  EXE_Funct,
   input  logic        EXE_Valid,
   input  logic        EXE_Hold,
   input  logic        EXE_Flush,
   output logic        md_busy,
   output logic        md_stall,
   output logic [31:0] md_rdata,
   output logic [31:0] md_hi,
   output logic [31:0] md_lo
);

   localparam logic [5:0] LAST_STEP = 6'(MD_STEPS - 1);

   mdState_e    state_q;
   logic [5:0]  cnt_q;
   logic [63:0] acc_q;
   logic [31:0] opB_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        negQ_q;
   logic        negR_q;
   logic        isDivOp_q;
   logic        divZero_q;

   logic        isSpecial;
   logic        isMult;
   logic        isMultu;
   logic        isDiv;
   logic        isDivu;
   logic        isMfhi;
   logic        isMthi;
   logic        isMflo;
   logic        isMtlo;
   logic        hiloUse;
   logic        act;
   logic        signedOp;
   logic        iterOp;
   logic        fastMul;
   logic [63:0] fastProd;
   logic [31:0] aMag;
   logic [31:0] bMag;
   logic        aNeg;
   logic        bNeg;

   logic [32:0] mulSum;
   logic [63:0] mulNext;
   logic [63:0] acc_d;
   logic [63:0] prodFix;
   logic [31:0] divRemStep;
   logic [31:0] divQuoStep;
   logic [31:0] divHi;
   logic [31:0] divLo;

   assign isSpecial = (EXE_OP == OP_SPECIAL);
   assign isMult    = isSpecial && (EXE_Funct == FN_MULT);
   assign isMultu   = isSpecial && (EXE_Funct == FN_MULTU);
   assign isDiv     = isSpecial && (EXE_Funct == FN_DIV);
   assign isDivu    = isSpecial && (EXE_Funct == FN_DIVU);
   assign isMfhi    = isSpecial && (EXE_Funct == FN_MFHI);
   assign isMthi    = isSpecial && (EXE_Funct == FN_MTHI);
   assign isMflo    = isSpecial && (EXE_Funct == FN_MFLO);
   assign isMtlo    = isSpecial && (EXE_Funct == FN_MTLO);
   assign hiloUse   = isMult | isMultu | isDiv | isDivu | isMfhi | isMthi | isMflo | isMtlo;

   assign act      = EXE_Valid & ~EXE_Hold & ~EXE_Flush;
   assign md_busy  = (state_q != ST_IDLE);
   assign md_stall = EXE_Valid & hiloUse & md_busy;
   assign md_rdata = isMfhi ? hi_q : (isMflo ? lo_q : 32'd0);
   assign md_hi    = hi_q;
   assign md_lo    = lo_q;

   assign signedOp = isMult | isDiv;
   assign aNeg     = signedOp & EXE_busA[31];
   assign bNeg     = signedOp & EXE_busB[31];
   assign aMag     = absVal(EXE_busA, signedOp);
   assign bMag     = absVal(EXE_busB, signedOp);

`ifdef MULDIV_FAST_MUL_EN
   assign iterOp   = isDiv | isDivu;
   assign fastMul  = isMult | isMultu;
   // Sign-extending both operands to 64 bits makes the modulo-2^64 product equal the signed product.
   assign fastProd = isMult ? ({{32{EXE_busA[31]}}, EXE_busA} * {{32{EXE_busB[31]}}, EXE_busB})
                            : ({32'd0, EXE_busA} * {32'd0, EXE_busB});
`else
   assign iterOp   = isMult | isMultu | isDiv | isDivu;
   assign fastMul  = 1'b0;
   assign fastProd = 64'd0;
`endif

   // Shift-add multiply: acc holds {partial product, remaining multiplier bits}.
   assign mulSum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opB_q : 32'd0)};
   assign mulNext = {mulSum, acc_q[31:1]};
   assign prodFix = negQ_q ? (64'd0 - acc_q) : acc_q;

   exe_div_core u_divCore (
      .rem_i     (acc_q[63:32]),
      .quo_i     (acc_q[31:0]),
      .divisor_i (opB_q),
      .negQ_i    (negQ_q),
      .negR_i    (negR_q),
      .divZero_i (divZero_q),
      .remStep_o (divRemStep),
      .quoStep_o (divQuoStep),
      .hi_o      (divHi),
      .lo_o      (divLo)
   );

   assign acc_d = isDivOp_q ? {divRemStep, divQuoStep} : mulNext;

   // Once started, an operation ignores EXE_Hold/EXE_Flush: its instruction has already left EXE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 6'd0;
         acc_q     <= 64'd0;
         opB_q     <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         negQ_q    <= 1'b0;
         negR_q    <= 1'b0;
         isDivOp_q <= 1'b0;
         divZero_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (act) begin
                  if (iterOp) begin
                     acc_q     <= {32'd0, aMag};
                     opB_q     <= bMag;
                     negQ_q    <= aNeg ^ bNeg;
                     negR_q    <= aNeg;
                     isDivOp_q <= isDiv | isDivu;
                     divZero_q <= (EXE_busB == 32'd0);
                     cnt_q     <= 6'd0;
                     state_q   <= ST_RUN;
                  end else if (fastMul) begin
                     hi_q <= fastProd[63:32];
                     lo_q <= fastProd[31:0];
                  end else if (isMthi) begin
                     hi_q <= EXE_busA;
                  end else if (isMtlo) begin
                     lo_q <= EXE_busA;
                  end
               end
            end
            ST_RUN: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == LAST_STEP) begin
                  state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (isDivOp_q) begin
                  hi_q <= divHi;
                  lo_q <= divLo;
               end else begin
                  hi_q <= prodFix[63:32];
                  lo_q <= prodFix[31:0];
               end
               cnt_q   <= 6'd0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
